// File: rtl/buffer_fifo_ctrl_if.sv
// rtl/buffer_fifo_ctrl_if.sv - stream and dpram signal bundle for buffer_fifo_ctrl
//   in_*  : write stream into the controller (data/valid/ready)
//   out_* : read stream out of the controller (data/valid/ready)
//   mem_* : dpram write port, read port and read data
//   slave  : controller view; master : producer/consumer/dpram view
interface buffer_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [ADDR_WIDTH-1:0] mem_wraddress;
  logic                  mem_wren;
  logic [ADDR_WIDTH-1:0] mem_rdaddress;
  logic                  mem_rden;
  logic [DATA_WIDTH-1:0] mem_q;

  modport slave (
    input  in_data, in_valid, out_ready, mem_q,
    output in_ready, out_data, out_valid,
           mem_data, mem_wraddress, mem_wren, mem_rdaddress, mem_rden
  );

  modport master (
    output in_data, in_valid, out_ready, mem_q,
    input  in_ready, out_data, out_valid,
           mem_data, mem_wraddress, mem_wren, mem_rdaddress, mem_rden
  );
endinterface

// File: rtl/buffer_fifo_ctrl.sv
// rtl/buffer_fifo_ctrl.sv - single-clock FIFO controller around buffer_dpram
//   clk, reset : single clock, synchronous active-high reset
//   flush      : synchronous clear of all contents
//   bus        : buffer_fifo_ctrl_if.slave (in stream, out stream, dpram ports)
//   level      : words held, dpram + in flight + output queue
//                (present only when BUFFER_FIFO_LEVEL_EN is defined)
module buffer_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 64,
  localparam int ADDR_WIDTH = $clog2(ENTRIES)
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  buffer_fifo_ctrl_if.slave bus
`ifdef BUFFER_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH+1:0] level
`endif
);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   mem_count, mem_count_n;
  logic                  inflight;
  logic [1:0]            q_cnt, q_cnt_n, cnt_after_pop;
  logic [DATA_WIDTH-1:0] head, tail, head_n, tail_n;
  logic [2:0]            occ;
  logic                  wren, rden, pop, clr;

  assign clr  = reset | flush;
  assign pop  = bus.out_valid & bus.out_ready;
  assign wren = bus.in_valid & bus.in_ready;

  // Queue slots already claimed (held + arriving); a new read is allowed only
  // if it still fits after this cycle's pop.
  assign occ  = {1'b0, q_cnt} + {2'b00, inflight};
  assign rden = !clr && (mem_count != '0) && (occ < (3'd2 + {2'b00, pop}));

  assign bus.in_ready      = !clr && (mem_count < (ADDR_WIDTH+1)'(ENTRIES));
  assign bus.out_valid     = !clr && (q_cnt != 2'd0);
  assign bus.out_data      = reset ? '0 : head;
  assign bus.mem_data      = bus.in_data;
  assign bus.mem_wren      = wren;
  assign bus.mem_wraddress = wr_ptr;
  assign bus.mem_rden      = rden;
  assign bus.mem_rdaddress = rd_ptr;

  always_comb begin
    head_n        = head;
    tail_n        = tail;
    cnt_after_pop = q_cnt - {1'b0, pop};
    if (pop) begin
      head_n = tail;
    end
    // The word read last cycle is on mem_q now; it goes to the first free slot.
    if (inflight) begin
      if (cnt_after_pop == 2'd0) begin
        head_n = bus.mem_q;
      end else begin
        tail_n = bus.mem_q;
      end
    end
    q_cnt_n     = cnt_after_pop + {1'b0, inflight};
    mem_count_n = mem_count + (ADDR_WIDTH+1)'(wren) - (ADDR_WIDTH+1)'(rden);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      inflight  <= 1'b0;
      q_cnt     <= 2'd0;
      head      <= '0;
      tail      <= '0;
    end else begin
      // ENTRIES is a power of two, so pointer wrap is natural overflow.
      wr_ptr    <= wr_ptr + ADDR_WIDTH'(wren);
      rd_ptr    <= rd_ptr + ADDR_WIDTH'(rden);
      mem_count <= mem_count_n;
      inflight  <= rden;
      q_cnt     <= q_cnt_n;
      head      <= head_n;
      tail      <= tail_n;
    end
  end

`ifdef BUFFER_FIFO_LEVEL_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      level <= '0;
    end else begin
      level <= (ADDR_WIDTH+2)'(mem_count_n) + (ADDR_WIDTH+2)'(rden) + (ADDR_WIDTH+2)'(q_cnt_n);
    end
  end
`endif

endmodule
